// File: rtl/j202_wb_pkg.sv
// j202_wb_pkg: shared types for the j202 Wishbone master bridge.
// Holds the bus widths, the bridge state encoding and the command record
// that the bridge latches onto the Wishbone outputs.
package j202_wb_pkg;

  localparam int WB_AW = 32;
  localparam int WB_DW = 32;
  localparam int WB_SW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic             we;
    logic [WB_AW-1:0] adr;
    logic [WB_DW-1:0] dat;
    logic [WB_SW-1:0] sel;
  } cmd_t;

endpackage

// File: rtl/j202_wb_master_bridge_if.sv
// j202_wb_master_bridge_if: command stream, response stream and Wishbone
// classic initiator signals of the j202 bridge.
//   master modport : the bridge (accepts cmd, drives rsp and wbm_* outputs)
//   slave modport  : the environment (drives cmd, consumes rsp, responds on bus)
interface j202_wb_master_bridge_if;
  import j202_wb_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_we;
  logic [WB_AW-1:0] cmd_adr;
  logic [WB_DW-1:0] cmd_dat;
  logic [WB_SW-1:0] cmd_sel;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WB_DW-1:0] rsp_dat;
  logic             rsp_err;

  logic             wbm_cyc_o;
  logic             wbm_stb_o;
  logic             wbm_we_o;
  logic [WB_AW-1:0] wbm_adr_o;
  logic [WB_DW-1:0] wbm_dat_o;
  logic [WB_SW-1:0] wbm_sel_o;
  logic             wbm_ack_i;
  logic [WB_DW-1:0] wbm_dat_i;

  modport master (
    input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel,
    output cmd_ready,
    output rsp_valid, rsp_dat, rsp_err,
    input  rsp_ready,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
    input  wbm_ack_i, wbm_dat_i
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel,
    input  cmd_ready,
    input  rsp_valid, rsp_dat, rsp_err,
    output rsp_ready,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
    output wbm_ack_i, wbm_dat_i
  );

endinterface

// File: rtl/j202_wb_timeout_ctr.sv
// j202_wb_timeout_ctr: cycle counter with synchronous clear and enable.
// tc is high while the count equals TIMEOUT_CYCLES-1.
//   clk, rst : clock and synchronous active-high reset
//   clr      : force count to zero
//   en       : advance count by one
//   tc       : terminal count reached
module j202_wb_timeout_ctr #(
  parameter int TO_W           = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [TO_W-1:0] TC_VAL = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt_q <= '0;
    else if (en)
      cnt_q <= cnt_q + TO_W'(1);
  end

  assign tc = (cnt_q == TC_VAL);

endmodule

// File: rtl/j202_wb_master_bridge.sv
// j202_wb_master_bridge: Wishbone classic (B3) single-cycle initiator.
// Turns each accepted command into one CYC/STB cycle and returns read data
// or a timeout error on the response stream.
//   wb_clk_i, wb_rst_i : clock, synchronous active-high reset
//   bus                : command / response / Wishbone signals (master side)
//   busy_o             : high whenever the bridge is not IDLE
module j202_wb_master_bridge
  import j202_wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  j202_wb_master_bridge_if.master bus,
  output logic                    busy_o
);

  state_e           state_q, state_d;
  cmd_t             cmd_q, cmd_d;
  logic [WB_DW-1:0] rsp_dat_q, rsp_dat_d;
  logic             rsp_err_q, rsp_err_d;
  logic             ctr_clr, ctr_en, ctr_tc;

  j202_wb_timeout_ctr #(
    .TO_W           (TO_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk (wb_clk_i),
    .rst (wb_rst_i),
    .clr (ctr_clr),
    .en  (ctr_en),
    .tc  (ctr_tc)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= IDLE;
      cmd_q     <= '0;
      rsp_dat_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      rsp_dat_q <= rsp_dat_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    rsp_dat_d = rsp_dat_q;
    rsp_err_d = rsp_err_q;
    ctr_clr   = 1'b0;
    ctr_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          cmd_d   = '{we: bus.cmd_we, adr: bus.cmd_adr,
                      dat: bus.cmd_dat, sel: bus.cmd_sel};
          ctr_clr = 1'b1;
          state_d = BUS;
        end
      end
      BUS: begin
        // Ack is checked before the terminal count so a last-cycle ack wins.
        if (bus.wbm_ack_i) begin
          rsp_dat_d = cmd_q.we ? '0 : bus.wbm_dat_i;
          rsp_err_d = 1'b0;
          state_d   = RESP;
        end else if (ctr_tc) begin
          rsp_dat_d = '0;
          rsp_err_d = 1'b1;
          state_d   = RESP;
        end else begin
          ctr_en = 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // CYC/STB and rsp_valid are decoded straight from the registered state,
  // so they are glitch-free and drop on the same edge as the state change.
  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.wbm_cyc_o = (state_q == BUS);
  assign bus.wbm_stb_o = (state_q == BUS);
  assign bus.wbm_we_o  = cmd_q.we;
  assign bus.wbm_adr_o = cmd_q.adr;
  assign bus.wbm_dat_o = cmd_q.dat;
  assign bus.wbm_sel_o = cmd_q.sel;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_dat   = rsp_dat_q;
  assign bus.rsp_err   = rsp_err_q;
  assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_j202_wb_master_bridge.sv
// tb_j202_wb_master_bridge: bench for the j202 Wishbone master bridge.
module tb_j202_wb_master_bridge;

  localparam int TO = 8;

  logic clk;
  logic rst;
  logic busy;
  int   total;
  int   bad;

  j202_wb_master_bridge_if bus_if ();

  j202_wb_master_bridge #(
    .TIMEOUT_CYCLES (TO),
    .TO_W           (8)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus_if),
    .busy_o   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          ack_cycle;  // STB cycle (1-based) on which ack is driven; 0 = never
    logic [31:0] rdata;
    int          rsp_wait;
    int          exp_stb;
    logic        exp_err;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Transaction-level expectation: an ack on STB cycle k (1..TO) ends the
  // cycle after k STB cycles; otherwise STB lasts TO cycles and errors out.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    if (v.ack_cycle >= 1 && v.ack_cycle <= TO) begin
      r.exp_stb = v.ack_cycle;
      r.exp_err = 1'b0;
      r.exp_dat = v.we ? 32'h0 : v.rdata;
    end else begin
      r.exp_stb = TO;
      r.exp_err = 1'b1;
      r.exp_dat = 32'h0;
    end
    return r;
  endfunction

  // Called at a falling edge with the bridge idle; returns at a falling edge idle.
  task automatic run_txn(input vec_t v);
    int stb;
    chk("idle_cmd_ready", 32'(bus_if.cmd_ready), 32'd1);
    chk("idle_cyc", 32'(bus_if.wbm_cyc_o), 32'd0);
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_we    = v.we;
    bus_if.cmd_adr   = v.adr;
    bus_if.cmd_dat   = v.dat;
    bus_if.cmd_sel   = v.sel;
    @(negedge clk);
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_we    = ~v.we;
    bus_if.cmd_adr   = $urandom;
    bus_if.cmd_dat   = $urandom;
    bus_if.cmd_sel   = 4'($urandom);
    stb = 0;
    for (int t = 0; t < 300 && bus_if.wbm_stb_o; t++) begin
      stb++;
      chk("bus_cyc", 32'(bus_if.wbm_cyc_o), 32'd1);
      chk("bus_we", 32'(bus_if.wbm_we_o), 32'(v.we));
      chk("bus_adr", bus_if.wbm_adr_o, v.adr);
      chk("bus_dat_o", bus_if.wbm_dat_o, v.dat);
      chk("bus_sel", 32'(bus_if.wbm_sel_o), 32'(v.sel));
      chk("bus_cmd_ready", 32'(bus_if.cmd_ready), 32'd0);
      chk("bus_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
      chk("bus_busy", 32'(busy), 32'd1);
      bus_if.wbm_ack_i = (stb == v.ack_cycle);
      bus_if.wbm_dat_i = (stb == v.ack_cycle) ? v.rdata : $urandom;
      @(negedge clk);
    end
    bus_if.wbm_ack_i = 1'b0;
    chk("stb_cycles", 32'(stb), 32'(v.exp_stb));
    chk("rsp_valid", 32'(bus_if.rsp_valid), 32'd1);
    chk("rsp_err", 32'(bus_if.rsp_err), 32'(v.exp_err));
    chk("rsp_dat", bus_if.rsp_dat, v.exp_dat);
    chk("rsp_cyc", 32'(bus_if.wbm_cyc_o), 32'd0);
    for (int w = 0; w < v.rsp_wait; w++) begin
      bus_if.wbm_ack_i = 1'($urandom_range(0, 1));
      bus_if.wbm_dat_i = $urandom;
      @(negedge clk);
      chk("hold_rsp_valid", 32'(bus_if.rsp_valid), 32'd1);
      chk("hold_rsp_dat", bus_if.rsp_dat, v.exp_dat);
      chk("hold_rsp_err", 32'(bus_if.rsp_err), 32'(v.exp_err));
      chk("hold_cmd_ready", 32'(bus_if.cmd_ready), 32'd0);
      chk("hold_cyc", 32'(bus_if.wbm_cyc_o), 32'd0);
    end
    bus_if.wbm_ack_i = 1'b0;
    bus_if.rsp_ready = 1'b1;
    @(negedge clk);
    bus_if.rsp_ready = 1'b0;
    chk("done_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    chk("done_cmd_ready", 32'(bus_if.cmd_ready), 32'd1);
  endtask

  initial begin
    vec_t v;
    logic [31:0] adr_snap, rdat_snap;
    total = 0;
    bad   = 0;
    rst = 1'b1;
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_we    = 1'b0;
    bus_if.cmd_adr   = '0;
    bus_if.cmd_dat   = '0;
    bus_if.cmd_sel   = '0;
    bus_if.rsp_ready = 1'b0;
    bus_if.wbm_ack_i = 1'b0;
    bus_if.wbm_dat_i = '0;

    tbl[0] = '{we:1'b0, adr:32'h3000_0004, dat:32'h0,         sel:4'hF, ack_cycle:3, rdata:32'hCAFE_F00D, rsp_wait:0, exp_stb:3, exp_err:1'b0, exp_dat:32'hCAFE_F00D};
    tbl[1] = '{we:1'b1, adr:32'h3000_0000, dat:32'h1234_5678, sel:4'h3, ack_cycle:1, rdata:32'hDEAD_BEEF, rsp_wait:0, exp_stb:1, exp_err:1'b0, exp_dat:32'h0};
    tbl[2] = '{we:1'b0, adr:32'h3000_0008, dat:32'h0,         sel:4'hF, ack_cycle:0, rdata:32'h1111_2222, rsp_wait:1, exp_stb:8, exp_err:1'b1, exp_dat:32'h0};
    tbl[3] = '{we:1'b0, adr:32'h3000_000C, dat:32'h0,         sel:4'hF, ack_cycle:8, rdata:32'hA5A5_5A5A, rsp_wait:0, exp_stb:8, exp_err:1'b0, exp_dat:32'hA5A5_5A5A};
    tbl[4] = '{we:1'b1, adr:32'h3000_0010, dat:32'hFFFF_0000, sel:4'hC, ack_cycle:0, rdata:32'h0,         rsp_wait:2, exp_stb:8, exp_err:1'b1, exp_dat:32'h0};
    tbl[5] = '{we:1'b0, adr:32'h0000_0003, dat:32'h0,         sel:4'h1, ack_cycle:1, rdata:32'h0000_0001, rsp_wait:5, exp_stb:1, exp_err:1'b0, exp_dat:32'h0000_0001};
    tbl[6] = '{we:1'b0, adr:32'h3000_0014, dat:32'h0,         sel:4'hF, ack_cycle:9, rdata:32'h7777_8888, rsp_wait:0, exp_stb:8, exp_err:1'b1, exp_dat:32'h0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_cyc", 32'(bus_if.wbm_cyc_o), 32'd0);
    chk("rst_stb", 32'(bus_if.wbm_stb_o), 32'd0);
    chk("rst_we", 32'(bus_if.wbm_we_o), 32'd0);
    chk("rst_adr", bus_if.wbm_adr_o, 32'd0);
    chk("rst_dat_o", bus_if.wbm_dat_o, 32'd0);
    chk("rst_sel", 32'(bus_if.wbm_sel_o), 32'd0);
    chk("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    chk("rst_rsp_dat", bus_if.rsp_dat, 32'd0);
    chk("rst_rsp_err", 32'(bus_if.rsp_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd_ready", 32'(bus_if.cmd_ready), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors
    for (int i = 0; i < 7; i++) run_txn(tbl[i]);

    // Stray ack while idle changes nothing
    adr_snap  = bus_if.wbm_adr_o;
    rdat_snap = bus_if.rsp_dat;
    for (int i = 0; i < 3; i++) begin
      bus_if.wbm_ack_i = 1'b1;
      bus_if.wbm_dat_i = $urandom;
      @(negedge clk);
      chk("stray_cyc", 32'(bus_if.wbm_cyc_o), 32'd0);
      chk("stray_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
      chk("stray_busy", 32'(busy), 32'd0);
      chk("stray_adr", bus_if.wbm_adr_o, adr_snap);
      chk("stray_rsp_dat", bus_if.rsp_dat, rdat_snap);
    end
    bus_if.wbm_ack_i = 1'b0;

    // Backpressure with the next command already waiting
    bus_if.cmd_valid = 1'b1; bus_if.cmd_we = 1'b0;
    bus_if.cmd_adr = 32'h1000_0000; bus_if.cmd_dat = 32'h0; bus_if.cmd_sel = 4'hF;
    @(negedge clk);
    bus_if.cmd_valid = 1'b0;
    chk("bp_stb1", 32'(bus_if.wbm_stb_o), 32'd1);
    @(negedge clk);
    chk("bp_stb2", 32'(bus_if.wbm_stb_o), 32'd1);
    bus_if.wbm_ack_i = 1'b1; bus_if.wbm_dat_i = 32'h1122_3344;
    @(negedge clk);
    bus_if.wbm_ack_i = 1'b0;
    chk("bp_rsp_valid", 32'(bus_if.rsp_valid), 32'd1);
    chk("bp_rsp_dat", bus_if.rsp_dat, 32'h1122_3344);
    bus_if.cmd_valid = 1'b1; bus_if.cmd_we = 1'b1;
    bus_if.cmd_adr = 32'h2000_0008; bus_if.cmd_dat = 32'h0000_0055; bus_if.cmd_sel = 4'hC;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(bus_if.rsp_valid), 32'd1);
      chk("bp_hold_dat", bus_if.rsp_dat, 32'h1122_3344);
      chk("bp_hold_cmd_ready", 32'(bus_if.cmd_ready), 32'd0);
      chk("bp_hold_cyc", 32'(bus_if.wbm_cyc_o), 32'd0);
    end
    bus_if.rsp_ready = 1'b1;
    @(negedge clk);
    bus_if.rsp_ready = 1'b0;
    chk("bp_rel_valid", 32'(bus_if.rsp_valid), 32'd0);
    chk("bp_rel_cmd_ready", 32'(bus_if.cmd_ready), 32'd1);
    chk("bp_rel_cyc", 32'(bus_if.wbm_cyc_o), 32'd0);
    @(negedge clk);
    bus_if.cmd_valid = 1'b0;
    chk("bp_next_cyc", 32'(bus_if.wbm_cyc_o), 32'd1);
    chk("bp_next_adr", bus_if.wbm_adr_o, 32'h2000_0008);
    chk("bp_next_we", 32'(bus_if.wbm_we_o), 32'd1);
    chk("bp_next_dat_o", bus_if.wbm_dat_o, 32'h0000_0055);
    chk("bp_next_sel", 32'(bus_if.wbm_sel_o), 32'hC);
    bus_if.wbm_ack_i = 1'b1; bus_if.wbm_dat_i = 32'h9999_9999;
    @(negedge clk);
    bus_if.wbm_ack_i = 1'b0;
    chk("bp_wr_valid", 32'(bus_if.rsp_valid), 32'd1);
    chk("bp_wr_dat", bus_if.rsp_dat, 32'h0);
    chk("bp_wr_err", 32'(bus_if.rsp_err), 32'd0);
    bus_if.rsp_ready = 1'b1;
    @(negedge clk);
    bus_if.rsp_ready = 1'b0;
    chk("bp_wr_done", 32'(bus_if.rsp_valid), 32'd0);

    // Randomized transactions against the reference rules
    for (int i = 0; i < 40; i++) begin
      v.we        = 1'($urandom_range(0, 1));
      v.adr       = $urandom;
      v.dat       = $urandom;
      v.sel       = 4'($urandom);
      v.ack_cycle = int'($urandom_range(0, TO + 2));
      v.rdata     = $urandom;
      v.rsp_wait  = int'($urandom_range(0, 3));
      run_txn(model(v));
    end

    // Reset on the 2nd STB cycle of a read (coincident ack must not leak)
    bus_if.cmd_valid = 1'b1; bus_if.cmd_we = 1'b0;
    bus_if.cmd_adr = 32'h3000_0010; bus_if.cmd_sel = 4'hF;
    @(negedge clk);
    bus_if.cmd_valid = 1'b0;
    chk("mr_stb1", 32'(bus_if.wbm_stb_o), 32'd1);
    @(negedge clk);
    chk("mr_stb2", 32'(bus_if.wbm_stb_o), 32'd1);
    rst = 1'b1;
    bus_if.wbm_ack_i = 1'b1; bus_if.wbm_dat_i = 32'hBAD0_BAD0;
    @(negedge clk);
    bus_if.wbm_ack_i = 1'b0;
    chk("mr_cyc", 32'(bus_if.wbm_cyc_o), 32'd0);
    chk("mr_stb", 32'(bus_if.wbm_stb_o), 32'd0);
    chk("mr_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    chk("mr_adr", bus_if.wbm_adr_o, 32'd0);
    chk("mr_rsp_dat", bus_if.rsp_dat, 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mr_post_valid", 32'(bus_if.rsp_valid), 32'd0);
      chk("mr_post_cmd_ready", 32'(bus_if.cmd_ready), 32'd1);
      chk("mr_post_cyc", 32'(bus_if.wbm_cyc_o), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
